// File: rtl/scalar_dump_pkg.sv
// Shared definitions for the scalar register-bank dump reader.
// Optional feature macro: SCALAR_DUMP_CHECKSUM_EN (XOR checksum word after the window).
package scalar_dump_pkg;

    localparam int SCALAR_ADDR_W = 4;
    localparam int SCALAR_DATA_W = 32;

    // CSUM is always part of the encoding so both builds share one state type.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        HOLD = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } dump_state_e;

    // Number of data words in a window; the window wraps from the top register to 0.
    function automatic logic [SCALAR_ADDR_W:0] window_words(
        input logic [SCALAR_ADDR_W-1:0] first,
        input logic [SCALAR_ADDR_W-1:0] last
    );
        logic [SCALAR_ADDR_W-1:0] span;
        span = last - first;
        return {1'b0, span} + {{SCALAR_ADDR_W{1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/scalar_reg_dump.sv
// Sequential reader for the scalar register bank: walks rd_addr across a
// programmed window and streams each word out on a valid/ready interface.
// Optional feature macro: SCALAR_DUMP_CHECKSUM_EN appends an XOR checksum word
// (out_addr = last register of the window) before done.
module scalar_reg_dump
    import scalar_dump_pkg::*;
#(
    parameter int ADDR_W = SCALAR_ADDR_W,
    parameter int DATA_W = SCALAR_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    dump_state_e       state_r;
    dump_state_e       state_nx_s;
    logic [ADDR_W-1:0] cur_r;
    logic [ADDR_W-1:0] last_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              busy_r;
    logic              done_r;
    logic              hs_s;
    logic              last_word_s;
`ifdef SCALAR_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_r;
`endif

    assign rd_addr   = cur_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_addr  = out_addr_r;
    assign busy      = busy_r;
    assign done      = done_r;

    // Next-state decode; a word leaves only on the valid/ready handshake.
    always_comb begin
        hs_s        = out_valid_r & out_ready;
        last_word_s = (cur_r == last_r);
        state_nx_s  = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx_s = READ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            READ: begin
                state_nx_s = HOLD;
            end
            HOLD: begin
                if (hs_s && last_word_s) begin
`ifdef SCALAR_DUMP_CHECKSUM_EN
                    state_nx_s = CSUM;
`else
                    state_nx_s = DONE;
`endif
                end else if (hs_s) begin
                    state_nx_s = READ;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            CSUM: begin
`ifdef SCALAR_DUMP_CHECKSUM_EN
                if (hs_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CSUM;
                end
`else
                state_nx_s = IDLE;
`endif
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Window capture on an accepted start and cursor advance after each accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_r  <= {ADDR_W{1'b0}};
            last_r <= {ADDR_W{1'b0}};
        end else if (state_r == IDLE && start) begin
            cur_r  <= first_addr;
            last_r <= last_addr;
        end else if (state_r == HOLD && hs_s && !last_word_s) begin
            cur_r  <= cur_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Output word register: data is sampled from the bank in READ and held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_addr_r  <= {ADDR_W{1'b0}};
        end else begin
            out_valid_r <= (state_nx_s == HOLD) || (state_nx_s == CSUM);
            if (state_r == READ) begin
                out_data_r <= rd_data;
                out_addr_r <= cur_r;
            end
`ifdef SCALAR_DUMP_CHECKSUM_EN
            else if (state_r == HOLD && state_nx_s == CSUM) begin
                // Fold in the word being accepted on this same edge.
                out_data_r <= csum_r ^ out_data_r;
                out_addr_r <= last_r;
            end
`endif
        end
    end

    // Status flags derived from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != IDLE);
            done_r <= (state_nx_s == DONE);
        end
    end

`ifdef SCALAR_DUMP_CHECKSUM_EN
    // XOR accumulator over accepted data words, cleared when a dump starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_r <= {DATA_W{1'b0}};
        end else if (state_r == IDLE && start) begin
            csum_r <= {DATA_W{1'b0}};
        end else if (state_r == HOLD && hs_s) begin
            csum_r <= csum_r ^ out_data_r;
        end
    end
`endif

endmodule

// File: tb/tb_scalar_reg_dump.sv
// Self-checking bench for scalar_reg_dump with a behavioural register bank
// and a window-expansion reference model.
module tb_scalar_reg_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  first_addr;
    logic [3:0]  last_addr;
    logic        busy;
    logic        done;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_addr;

    logic [31:0] bank [16];

    int checks;
    int failures;

    logic [3:0]  exp_addr [$];
    logic [31:0] exp_data [$];
    logic [3:0]  obs_addr [$];
    logic [31:0] obs_data [$];
    int          lat;
    int          done_cnt;
    int          busy_bad;
    int          unstable;
    bit          timed_out;

    scalar_reg_dump dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr)
    );

    assign rd_data = bank[rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: list of (address, data) words the window must produce.
    task automatic build_expected(input logic [3:0] f, input logic [3:0] l);
        int n;
        int a;
        logic [31:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = ((int'(l) - int'(f) + 16) % 16) + 1;
        x = 32'd0;
        for (int i = 0; i < n; i++) begin
            a = (int'(f) + i) % 16;
            exp_addr.push_back(4'(a));
            exp_data.push_back(bank[a]);
            x = x ^ bank[a];
        end
`ifdef SCALAR_DUMP_CHECKSUM_EN
        exp_addr.push_back(l);
        exp_data.push_back(x);
`endif
    endtask

    // Runs one dump, recording accepted words, latency, done pulses, busy and stability errors.
    task automatic do_dump(input logic [3:0] f, input logic [3:0] l, input int pct,
                           input int hold_cycles, input bit restart_mid);
        int cyc;
        int post;
        int hold_left;
        bit pend;
        logic [3:0]  p_addr;
        logic [31:0] p_data;
        obs_addr.delete();
        obs_data.delete();
        lat = -1; done_cnt = 0; busy_bad = 0; unstable = 0; timed_out = 1'b0;
        pend = 1'b0; p_addr = 4'd0; p_data = 32'd0;
        hold_left = hold_cycles;
        @(negedge clk);
        start = 1'b1; first_addr = f; last_addr = l; out_ready = 1'b0;
        cyc = 0; post = -1;
        while (1) begin
            @(negedge clk);
            cyc++;
            start = restart_mid && (cyc == 3);
            if (restart_mid && cyc == 3) begin
                first_addr = f + 4'd5;
                last_addr  = f + 4'd5;
            end
            if (pend && (!out_valid || out_addr !== p_addr || out_data !== p_data)) unstable++;
            if (out_valid && lat < 0) lat = cyc;
            if (done) done_cnt++;
            if (post < 0) begin
                if (busy !== 1'b1) busy_bad++;
            end else begin
                if (busy !== 1'b0) busy_bad++;
            end
            if (done && post < 0) post = 0;
            else if (post >= 0) post++;
            if (post >= 3) break;
            if (out_valid && hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = int'($urandom_range(99)) < pct;
            end
            pend = out_valid && !out_ready;
            p_addr = out_addr;
            p_data = out_data;
            if (out_valid && out_ready) begin
                obs_addr.push_back(out_addr);
                obs_data.push_back(out_data);
            end
            if (cyc > 800) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; first_addr = 4'd0; last_addr = 4'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", out_data); end
        checks++; if (out_addr !== 4'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", out_addr); end
        checks++; if (rd_addr !== 4'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release busy=%b valid=%b exp=0/0", busy, out_valid);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) bank[i] = $urandom;
        bank[1] = 32'd15; bank[2] = 32'd23;
        build_expected(4'd1, 4'd2);
        do_dump(4'd1, 4'd2, 100, 0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL basic_latency got=%0d exp=2", lat); end
        checks++; if (obs_addr.size() < 2 || obs_addr[0] !== 4'd1 || obs_data[0] !== 32'd15 ||
                      obs_addr[1] !== 4'd2 || obs_data[1] !== 32'd23) begin
            failures++; $display("FAIL basic_words got_n=%0d exp=(1,15),(2,23)", obs_addr.size());
        end
`ifdef SCALAR_DUMP_CHECKSUM_EN
        checks++; if (obs_addr.size() != 3 || obs_addr[2] !== 4'd2 || obs_data[2] !== 32'd24) begin
            failures++; $display("FAIL basic_csum got_n=%0d exp=3 words ending (2,24)", obs_addr.size());
        end
`else
        checks++; if (obs_addr.size() != 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", obs_addr.size()); end
`endif
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
        checks++; if (busy_bad != 0) begin failures++; $display("FAIL basic_busy got=%0d errors exp=0", busy_bad); end
    endtask

    task automatic test_backpressure();
        bank[1] = 32'd15; bank[2] = 32'd23;
        build_expected(4'd1, 4'd2);
        do_dump(4'd1, 4'd2, 100, 5, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL bp_timeout got=timeout exp=done"); end
        checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", unstable); end
        checks++; if (obs_addr.size() != exp_addr.size()) begin
            failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size(); i++) begin
            checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL bp_word%0d got=(%0d,%0h) exp=(%0d,%0h)", i,
                    (i < obs_addr.size()) ? obs_addr[i] : 4'hx, (i < obs_data.size()) ? obs_data[i] : 32'hx,
                    exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) bank[i] = 32'(i * 3);
        build_expected(4'd14, 4'd1);
        do_dump(4'd14, 4'd1, 70, 0, 1'b0);
        checks++; if (timed_out) begin failures++; $display("FAIL wrap_timeout got=timeout exp=done"); end
        checks++; if (obs_addr.size() < 4 || obs_addr[0] !== 4'd14 || obs_data[0] !== 32'd42 ||
                      obs_addr[1] !== 4'd15 || obs_data[1] !== 32'd45 || obs_addr[2] !== 4'd0 ||
                      obs_data[2] !== 32'd0 || obs_addr[3] !== 4'd1 || obs_data[3] !== 32'd3) begin
            failures++; $display("FAIL wrap_words got_n=%0d exp=14:42,15:45,0:0,1:3", obs_addr.size());
        end
        checks++; if (obs_addr.size() != exp_addr.size()) begin
            failures++; $display("FAIL wrap_count got=%0d exp=%0d", obs_addr.size(), exp_addr.size());
        end
        checks++; if (done_cnt != 1 || busy_bad != 0) begin
            failures++; $display("FAIL wrap_done got done=%0d busy_err=%0d exp=1/0", done_cnt, busy_bad);
        end
    endtask

    task automatic test_single_full();
        logic [3:0] fs [2];
        logic [3:0] ls [2];
        fs[0] = 4'd7; ls[0] = 4'd7;
        fs[1] = 4'd5; ls[1] = 4'd4;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 16; i++) bank[i] = $urandom;
            build_expected(fs[t], ls[t]);
            do_dump(fs[t], ls[t], 60, 0, 1'b0);
            checks++; if (timed_out) begin failures++; $display("FAIL win%0d_timeout got=timeout exp=done", t); end
            checks++; if (obs_addr.size() != exp_addr.size()) begin
                failures++; $display("FAIL win%0d_count got=%0d exp=%0d", t, obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    failures++; $display("FAIL win%0d_word%0d got_n=%0d exp=(%0d,%0h)", t, i,
                        obs_addr.size(), exp_addr[i], exp_data[i]);
                end
            end
            checks++; if (done_cnt != 1 || busy_bad != 0 || unstable != 0) begin
                failures++; $display("FAIL win%0d_ctl got done=%0d busy_err=%0d unstable=%0d exp=1/0/0",
                    t, done_cnt, busy_bad, unstable);
            end
        end
    endtask

    task automatic test_restart_ignored();
        for (int i = 0; i < 16; i++) bank[i] = $urandom;
        build_expected(4'd3, 4'd9);
        do_dump(4'd3, 4'd9, 80, 0, 1'b1);
        checks++; if (timed_out) begin failures++; $display("FAIL restart_timeout got=timeout exp=done"); end
        checks++; if (obs_addr.size() != exp_addr.size()) begin
            failures++; $display("FAIL restart_count got=%0d exp=%0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size(); i++) begin
            checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL restart_word%0d got_n=%0d exp=(%0d,%0h)", i,
                    obs_addr.size(), exp_addr[i], exp_data[i]);
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL restart_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_async_reset();
        int waited;
        int done_seen;
        @(negedge clk);
        start = 1'b1; first_addr = 4'd2; last_addr = 4'd6; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (out_valid !== 1'b1 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL arst_hold got=%b exp=1", out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL arst_immediate got valid=%b busy=%b exp=0/0", out_valid, busy);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checks++; if (done_seen != 0) begin failures++; $display("FAIL arst_no_done got=%0d exp=0", done_seen); end
        for (int i = 0; i < 16; i++) bank[i] = $urandom;
        build_expected(4'd11, 4'd13);
        do_dump(4'd11, 4'd13, 75, 0, 1'b0);
        checks++; if (obs_addr.size() != exp_addr.size() || timed_out) begin
            failures++; $display("FAIL arst_redump_count got=%0d exp=%0d", obs_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size(); i++) begin
            checks++;
            if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL arst_redump_word%0d got_n=%0d exp=(%0d,%0h)", i,
                    obs_addr.size(), exp_addr[i], exp_data[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] f;
        logic [3:0] l;
        int pct;
        for (int t = 0; t < 6; t++) begin
            f = 4'($urandom);
            l = 4'($urandom);
            pct = int'($urandom_range(70)) + 30;
            for (int i = 0; i < 16; i++) bank[i] = $urandom;
            build_expected(f, l);
            do_dump(f, l, pct, int'($urandom_range(3)), 1'b0);
            checks++; if (obs_addr.size() != exp_addr.size() || timed_out) begin
                failures++; $display("FAIL rand%0d_count win=%0d..%0d got=%0d exp=%0d", t, f, l,
                    obs_addr.size(), exp_addr.size());
            end
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (i >= obs_addr.size() || obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
                    failures++; $display("FAIL rand%0d_word%0d got_n=%0d exp=(%0d,%0h)", t, i,
                        obs_addr.size(), exp_addr[i], exp_data[i]);
                end
            end
            checks++; if (done_cnt != 1 || busy_bad != 0 || unstable != 0 || lat != 2) begin
                failures++; $display("FAIL rand%0d_ctl got done=%0d busy_err=%0d unstable=%0d lat=%0d exp=1/0/0/2",
                    t, done_cnt, busy_bad, unstable, lat);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 16; i++) bank[i] = 32'd0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_single_full();
        test_restart_ignored();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
